s2p_rx: RTL

S2P_RX -- requirements
Module: s2p_rx

---
 rtl/s2p_pkg.sv | 13 +
 rtl/s2p_rx_sync2.sv | 24 ++
 rtl/s2p_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared types and defaults for the s2p_rx serial-to-parallel receiver.
// Optional parity support is enabled with the S2P_RX_PARITY_EN macro.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/s2p_rx_sync2.sv
// Two-flop synchronizer for bringing one asynchronous bit into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: oversamples s_clk/sin in the clk domain and delivers words with valid/ack.
// Define S2P_RX_PARITY_EN to expect a trailing even-parity bit per frame and report it on perr.
module s2p_rx
    import s2p_pkg::*;
#(
    parameter int DATA_BITS = 16,
    parameter int DIR       = 0,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_clrn,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] PData,
    output logic                 valid,
    input  logic                 ack,
    output logic                 ovr,
    output logic                 ferr,
    output logic                 perr
);

`ifdef S2P_RX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 1;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif
    localparam int CNT_W  = $clog2(DATA_BITS + 2);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic s_clk_s, s_clrn_s, sin_s;
    logic s_clk_prev_q;
    logic s_edge;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] shift_base, shift_next;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [DATA_BITS-1:0]  pdata_q, pdata_d;
    logic [DATA_BITS-1:0]  frame_data;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  ferr_q, ferr_d;

    sync2 u_sync_sclk  (.clk(clk), .rst(rst), .d(s_clk),  .q(s_clk_s));
    sync2 u_sync_sclrn (.clk(clk), .rst(rst), .d(s_clrn), .q(s_clrn_s));
    sync2 u_sync_sin   (.clk(clk), .rst(rst), .d(sin),    .q(sin_s));

    assign s_edge = s_clk_s & ~s_clk_prev_q;

    // A new frame always starts from an empty register, whatever the last frame left behind.
    assign shift_base = (state_q == IDLE) ? '0 : shift_q;
    assign shift_next = (DIR == 0) ? {shift_base[FRAME_BITS-2:0], sin_s}
                                   : {sin_s, shift_base[FRAME_BITS-1:1]};

`ifdef S2P_RX_PARITY_EN
    logic frame_par;
    logic perr_q, perr_d;

    always_comb begin
        if (DIR == 0) begin
            frame_data = shift_q[FRAME_BITS-1:1];
            frame_par  = shift_q[0];
        end else begin
            frame_data = shift_q[FRAME_BITS-2:0];
            frame_par  = shift_q[FRAME_BITS-1];
        end
    end

    always_comb begin
        perr_d = perr_q;
        if (s_clrn_s && state_q == HOLD)
            perr_d = ^{frame_data, frame_par};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign perr = perr_q;
`else
    assign frame_data = shift_q;
    assign perr       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        pdata_d = pdata_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;

        if (valid_q && ack)
            valid_d = 1'b0;

        if (!s_clrn_s) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
            idle_d  = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_edge) begin
                        shift_d = shift_next;
                        cnt_d   = CNT_W'(1);
                        idle_d  = '0;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (s_edge) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + CNT_W'(1);
                        idle_d  = '0;
                        if (cnt_q == CNT_W'(FRAME_BITS - 1))
                            state_d = HOLD;
                    end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        shift_d = '0;
                        cnt_d   = '0;
                        idle_d  = '0;
                        ferr_d  = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                HOLD: begin
                    // An ack landing in the delivery cycle retires the old word, so no overrun.
                    pdata_d = frame_data;
                    valid_d = 1'b1;
                    if (valid_q && !ack)
                        ovr_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s_clk_prev_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            pdata_q      <= '0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_clk_prev_q <= s_clk_s;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            pdata_q      <= pdata_d;
            valid_q      <= valid_d;
            ovr_q        <= ovr_d;
            ferr_q       <= ferr_d;
        end
    end

    assign PData = pdata_q;
    assign valid = valid_q;
    assign ovr   = ovr_q;
    assign ferr  = ferr_q;

endmodule
